// File: rtl/panel_image_loader.sv
// rtl/panel_image_loader.sv - streams 12-bit words into the PDP-8 front panel (base load, deposits, start PC, run)
// Optional PANEL_LOADER_ZERO_FILL_EN: zero-fill every location past the image up to 4096.
module panel_image_loader #(
    parameter int          SETUP_CYC = 10,
    parameter int          PULSE_CYC = 10,
    parameter int          HOLD_CYC  = 10,
    parameter logic [11:0] BASE_ADDR = 12'o0000,
    parameter logic [11:0] START_PC  = 12'o0200
) (
    input  logic        clk,
    input  logic        btnCpuReset,
    input  logic        start,
    input  logic        word_valid,
    input  logic [11:0] word_data,
    input  logic        word_last,
    output logic        word_ready,
    output logic [12:0] sw_out,
    output logic        deposit,
    output logic        load_pc,
    output logic        busy,
    output logic        done,
    output logic [12:0] word_count
);

    localparam int          TW        = 16;
    localparam logic [12:0] MEM_WORDS = 13'd4096;

    typedef enum logic [3:0] {
        S_IDLE,
        S_BASE_SETUP,
        S_BASE_PULSE,
        S_BASE_HOLD,
        S_WAIT_WORD,
        S_DEP_SETUP,
        S_DEP_PULSE,
        S_DEP_HOLD,
        S_START_SETUP,
        S_START_PULSE,
        S_START_HOLD,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [TW-1:0] r_timer;
    logic          r_last;
    logic [12:0]   r_sw;
    logic          r_deposit;
    logic          r_load_pc;
    logic          r_word_ready;
    logic          r_busy;
    logic          r_done;
    logic [12:0]   r_word_count;

    logic w_timer_done;
    logic w_handshake;
    logic w_enter;
    logic w_full;

    assign w_timer_done = (r_timer == '0);
    assign w_handshake  = r_word_ready & word_valid;
    assign w_enter      = (w_state_next != r_state);
    assign w_full       = (r_word_count == MEM_WORDS);

    // Timer holds (phase length - 1) on entry, so a phase lasts exactly its parameter.
    function automatic logic [TW-1:0] phase_len(input state_t s);
        case (s)
            S_BASE_SETUP, S_DEP_SETUP, S_START_SETUP: phase_len = TW'(SETUP_CYC - 1);
            S_BASE_PULSE, S_DEP_PULSE, S_START_PULSE: phase_len = TW'(PULSE_CYC - 1);
            S_BASE_HOLD,  S_DEP_HOLD,  S_START_HOLD:  phase_len = TW'(HOLD_CYC - 1);
            default:                                  phase_len = '0;
        endcase
    endfunction

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) w_state_next = S_BASE_SETUP;
            end
            S_BASE_SETUP:  if (w_timer_done) w_state_next = S_BASE_PULSE;
            S_BASE_PULSE:  if (w_timer_done) w_state_next = S_BASE_HOLD;
            S_BASE_HOLD:   if (w_timer_done) w_state_next = S_WAIT_WORD;
            S_WAIT_WORD:   if (w_handshake)  w_state_next = S_DEP_SETUP;
            S_DEP_SETUP:   if (w_timer_done) w_state_next = S_DEP_PULSE;
            S_DEP_PULSE:   if (w_timer_done) w_state_next = S_DEP_HOLD;
            S_DEP_HOLD: begin
                if (w_timer_done) begin
                    if (w_full) begin
                        w_state_next = S_START_SETUP;
                    end else if (r_last) begin
`ifdef PANEL_LOADER_ZERO_FILL_EN
                        w_state_next = S_DEP_SETUP;
`else
                        w_state_next = S_START_SETUP;
`endif
                    end else begin
                        w_state_next = S_WAIT_WORD;
                    end
                end
            end
            S_START_SETUP: if (w_timer_done) w_state_next = S_START_PULSE;
            S_START_PULSE: if (w_timer_done) w_state_next = S_START_HOLD;
            S_START_HOLD:  if (w_timer_done) w_state_next = S_DONE;
            default:       w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge btnCpuReset) begin
        if (!btnCpuReset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_last       <= 1'b0;
            r_sw         <= '0;
            r_deposit    <= 1'b0;
            r_load_pc    <= 1'b0;
            r_word_ready <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_word_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_enter) begin
                r_timer <= phase_len(w_state_next);
            end else if (!w_timer_done) begin
                r_timer <= r_timer - 1'b1;
            end

            // Outputs are registered from the next state so they line up with it exactly.
            r_deposit    <= (w_state_next == S_DEP_PULSE);
            r_load_pc    <= (w_state_next == S_BASE_PULSE) || (w_state_next == S_START_PULSE);
            r_word_ready <= (w_state_next == S_WAIT_WORD);
            r_busy       <= (w_state_next != S_IDLE) && (w_state_next != S_DONE);
            r_done       <= (w_state_next == S_DONE);

            if (w_enter) begin
                case (w_state_next)
                    S_BASE_SETUP: begin
                        r_sw         <= {1'b0, BASE_ADDR};
                        r_word_count <= '0;
                        r_last       <= 1'b0;
                    end
                    S_DEP_SETUP: begin
                        // Entry from DEP_HOLD only happens while zero-filling.
                        if (r_state == S_WAIT_WORD) begin
                            r_sw[11:0] <= word_data;
                            r_last     <= word_last;
                        end else begin
                            r_sw[11:0] <= 12'o0000;
                        end
                    end
                    S_DEP_HOLD:    r_word_count <= r_word_count + 13'd1;
                    S_START_SETUP: r_sw[11:0]   <= START_PC;
                    S_DONE:        r_sw[12]     <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign word_ready = r_word_ready;
    assign sw_out     = r_sw;
    assign deposit    = r_deposit;
    assign load_pc    = r_load_pc;
    assign busy       = r_busy;
    assign done       = r_done;
    assign word_count = r_word_count;

endmodule

// File: tb/tb_panel_image_loader.sv
// tb/tb_panel_image_loader.sv - randomized bench for panel_image_loader with pulse-level reference model
module tb_panel_image_loader;

    localparam int          SA = 10, PA = 10, HA = 10;
    localparam int          SB = 1,  PB = 1,  HB = 1;
    localparam logic [11:0] BASE = 12'o0000;
    localparam logic [11:0] STPC = 12'o0200;
    localparam int          WORD_BUDGET = 300;
    localparam int          DONE_BUDGET = 20000;
`ifdef PANEL_LOADER_ZERO_FILL_EN
    localparam bit FILL = 1'b1;
    localparam bit SMALL_SEL = 1'b1;
`else
    localparam bit FILL = 1'b0;
    localparam bit SMALL_SEL = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, start_b;
    logic        word_valid, word_last;
    logic [11:0] word_data;

    logic        a_ready, b_ready, a_dep, b_dep, a_lpc, b_lpc;
    logic        a_busy, b_busy, a_done, b_done;
    logic [12:0] a_sw, b_sw, a_wc, b_wc;

    panel_image_loader #(.SETUP_CYC(SA), .PULSE_CYC(PA), .HOLD_CYC(HA)) dut_a (
        .clk(clk), .btnCpuReset(rst_n), .start(start_a),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(a_ready), .sw_out(a_sw), .deposit(a_dep), .load_pc(a_lpc),
        .busy(a_busy), .done(a_done), .word_count(a_wc)
    );

    panel_image_loader #(.SETUP_CYC(SB), .PULSE_CYC(PB), .HOLD_CYC(HB)) dut_b (
        .clk(clk), .btnCpuReset(rst_n), .start(start_b),
        .word_valid(word_valid), .word_data(word_data), .word_last(word_last),
        .word_ready(b_ready), .sw_out(b_sw), .deposit(b_dep), .load_pc(b_lpc),
        .busy(b_busy), .done(b_done), .word_count(b_wc)
    );

    logic        sel;
    logic [12:0] m_sw, m_wc;
    logic        m_dep, m_lpc, m_ready, m_busy, m_done;

    always_comb begin
        m_sw    = sel ? b_sw    : a_sw;
        m_wc    = sel ? b_wc    : a_wc;
        m_dep   = sel ? b_dep   : a_dep;
        m_lpc   = sel ? b_lpc   : a_lpc;
        m_ready = sel ? b_ready : a_ready;
        m_busy  = sel ? b_busy  : a_busy;
        m_done  = sel ? b_done  : a_done;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    logic [11:0] img [0:4096];
    logic [12:0] obs_q [$];
    int          dep_seen;
    int          accepted;

    // Pulse-level monitor: records every Deposit/Load_PC pulse and checks its timing envelope.
    bit          prev_pulse;
    int          width, stable, hold_left;
    logic [11:0] prev_sw, pval;
    logic        pkind;

    always @(negedge clk) begin
        int su, pu, ho;
        logic pulse;
        su = sel ? SB : SA;
        pu = sel ? PB : PA;
        ho = sel ? HB : HA;
        pulse = m_dep | m_lpc;
        if (!rst_n) begin
            prev_pulse = 1'b0;
            width      = 0;
            hold_left  = 0;
            stable     = 0;
            prev_sw    = m_sw[11:0];
        end else begin
            if (m_sw[11:0] === prev_sw) stable++;
            else stable = 1;
            prev_sw = m_sw[11:0];
            check("overlap", 32'(m_dep & m_lpc), 0);
            if (pulse && !prev_pulse) begin
                pkind = m_lpc;
                pval  = m_sw[11:0];
                width = 1;
                check("setup", 32'(stable - 1 >= su), 1);
                obs_q.push_back({m_lpc, m_sw[11:0]});
            end else if (pulse) begin
                width++;
                check("pulse_sw", 32'(m_sw[11:0]), 32'(pval));
                check("pulse_kind", 32'(m_lpc), 32'(pkind));
            end else if (prev_pulse) begin
                check("width", 32'(width), 32'(pu));
                hold_left = ho;
                if (!pkind) begin
                    dep_seen++;
                    check("wc_at_fall", 32'(m_wc), 32'(dep_seen));
                end
            end
            if (!pulse && hold_left > 0) begin
                check("hold_sw", 32'(m_sw[11:0]), 32'(pval));
                hold_left--;
            end
            if (m_ready) check("ready_cap", 32'(m_wc < 13'd4096), 1);
            prev_pulse = pulse;
        end
    end

    task automatic send_image(input int n, input bit give_last, input bit rand_valid);
        for (int i = 0; i < n; i++) begin
            int waited;
            bit acc;
            waited    = 0;
            acc       = 1'b0;
            word_data = img[i];
            word_last = give_last && (i == n - 1);
            while (!acc) begin
                word_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
                acc = m_ready && word_valid;
                if (acc) accepted++;
                @(posedge clk);
                #1;
                if (!acc) begin
                    waited++;
                    if (m_done) begin
                        word_valid = 1'b0;
                        word_last  = 1'b0;
                        return;
                    end
                    if (waited > WORD_BUDGET) begin
                        check("word_timeout", 32'(waited), WORD_BUDGET);
                        word_valid = 1'b0;
                        word_last  = 1'b0;
                        return;
                    end
                end
            end
        end
        word_valid = 1'b0;
        word_last  = 1'b0;
    endtask

    task automatic run_load(input bit s, input int n, input bit give_last, input bit rand_valid);
        logic [12:0] exp_q [$];
        int exp_dep, img_dep, cyc;
        sel = s;
        obs_q.delete();
        dep_seen = 0;
        accepted = 0;
        @(posedge clk);
        #1;
        if (s) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        check("start_busy", 32'(m_busy), 1);
        check("start_done", 32'(m_done), 0);
        check("start_wc", 32'(m_wc), 0);
        check("start_run", 32'(m_sw[12]), 0);

        send_image(n, give_last, rand_valid);
        cyc = 0;
        while (!m_done && cyc < DONE_BUDGET) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        repeat (2) @(posedge clk);
        #1;

        // Model: base load, image words (capped at 4096), optional zero fill, start PC load.
        img_dep = (n > 4096) ? 4096 : n;
        exp_dep = (FILL && give_last) ? 4096 : img_dep;
        exp_q.push_back({1'b1, BASE});
        for (int i = 0; i < exp_dep; i++) exp_q.push_back({1'b0, (i < img_dep) ? img[i] : 12'o0000});
        exp_q.push_back({1'b1, STPC});

        check("end_done", 32'(m_done), 1);
        check("end_busy", 32'(m_busy), 0);
        check("end_sw", 32'(m_sw), 32'({1'b1, STPC}));
        check("end_wc", 32'(m_wc), 32'(exp_dep));
        check("end_ready", 32'(m_ready), 0);
        check("accepted", 32'(accepted), 32'(img_dep));
        check("n_pulses", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check("pulse_seq", 32'(obs_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        int cyc;
        rst_n      = 1'b0;
        start_a    = 1'b0;
        start_b    = 1'b0;
        word_valid = 1'b0;
        word_last  = 1'b0;
        word_data  = '0;
        sel        = 1'b0;
        dep_seen   = 0;
        accepted   = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs_a", 32'({a_sw, a_dep, a_lpc, a_ready, a_busy, a_done, a_wc}), 0);
        check("rst_outs_b", 32'({b_sw, b_dep, b_lpc, b_ready, b_busy, b_done, b_wc}), 0);
        rst_n = 1'b1;

        // Start while busy is ignored; reset mid-deposit truncates the pulse at once.
        @(posedge clk);
        #1;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a    = 1'b0;
        word_data  = 12'o1234;
        word_valid = 1'b1;
        cyc = 0;
        while (!a_dep && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("dep_reached", 32'(a_dep), 1);
        word_valid = 1'b0;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check("busy_start_ignored", 32'({a_dep, a_busy}), 32'({1'b1, 1'b1}));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_dep_async", 32'(a_dep), 0);
        check("rst_mid_outs", 32'({a_sw, a_dep, a_lpc, a_ready, a_busy, a_done, a_wc}), 0);
        repeat (5) @(posedge clk);
        #1;
        check("rst_held_outs", 32'({a_sw, a_dep, a_lpc, a_ready, a_busy, a_done, a_wc}), 0);
        rst_n = 1'b1;

        img[0] = 12'o7300;
        img[1] = 12'o1205;
        img[2] = 12'o7402;
        run_load(SMALL_SEL, 3, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) img[i] = 12'($urandom);
        run_load(SMALL_SEL, 16, 1'b1, 1'b1);

        for (int i = 0; i < 5; i++) img[i] = 12'($urandom);
        run_load(1'b1, 5, 1'b1, 1'b1);

        for (int i = 0; i < 4097; i++) img[i] = 12'($urandom);
        run_load(1'b1, 4097, 1'b0, 1'b0);

        img[0] = 12'o4321;
        img[1] = 12'o0777;
        run_load(1'b1, 2, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
